// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS IF stage (PC register, PC+4, branch redirect, IF/ID register).
// Optional IF_PERF_CNT_EN adds saturating stall/flush/fetch counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_select_i,
  input  logic [31:0] branch_target_i,
  input  logic        pc_write_i,
  input  logic        if_write_i,
  input  logic        if_flush_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o,
  output logic [31:0] perf_fetch_cnt_o
`endif
);
  logic [31:0] pc_q, pc_d, pc_plus4, next_pc;
  logic [31:0] instr_q, instr_d, pc4_q, pc4_d;
  logic        valid_q, valid_d;
  assign pc_plus4 = pc_q + 32'd4;
  assign next_pc  = pc_select_i ? {branch_target_i[31:2], 2'b00} : pc_plus4;
  // flush outranks write; neither means a stall hold
  always_comb begin
    pc_d    = pc_write_i ? next_pc : pc_q;
    instr_d = if_flush_i ? NOP_INSTR : if_write_i ? imem_data_i : instr_q;
    pc4_d   = if_flush_i ? 32'd0 : if_write_i ? pc_plus4 : pc4_q;
    valid_d = if_flush_i ? 1'b0 : if_write_i ? 1'b1 : valid_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign if_id_pc4_o   = pc4_q;
  assign if_id_instr_o = instr_q;
  assign if_id_valid_o = valid_q;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_q, stall_d, flush_q, flush_d, fetch_q, fetch_d;
  always_comb begin
    stall_d = (!pc_write_i && ~&stall_q) ? stall_q + 32'd1 : stall_q;
    flush_d = (if_flush_i && ~&flush_q) ? flush_q + 32'd1 : flush_q;
    fetch_d = (!if_flush_i && if_write_i && ~&fetch_q) ? fetch_q + 32'd1 : fetch_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
      fetch_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      fetch_q <= fetch_d;
    end
  end
  assign perf_stall_cnt_o = stall_q;
  assign perf_flush_cnt_o = flush_q;
  assign perf_fetch_cnt_o = fetch_q;
`endif
endmodule
